// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-number controller and its decoder.
package sc_pkg;

  localparam int RND_W_DEF = 27;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } sc_state_t;

  // Unsigned "sample below operand" test; both operands arrive zero-extended.
  function automatic logic sn_lt(input logic [31:0] sample, input logic [31:0] value);
    return sample < value;
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Saturating ones counter with synchronous clear; shared with the SN-to-binary decoder.
module sc_ones_counter #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/halton_sng_ctrl.sv
// Turns a binary operand into a 2^LEN_LOG2-bit stochastic stream by comparing it
// against a bit-reversed-counter (base-2 Halton) generator, and counts the ones.
module halton_sng_ctrl
  import sc_pkg::*;
#(
  parameter int RND_W    = RND_W_DEF,
  parameter int PREC     = 12,
  parameter int LEN_LOG2 = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PREC-1:0]     in_value,
  input  logic [RND_W-1:0]    in_seed,
  output logic                rng_load,
  output logic [RND_W-1:0]    rng_seed,
  input  logic [RND_W-1:0]    rnd_in,
  output logic                sn_valid,
  output logic                sn_bit,
  output logic                done,
  output logic [LEN_LOG2:0]   ones_count,
  output logic                busy
);

  sc_state_t           state, state_next;
  logic [PREC-1:0]     value;
  logic [LEN_LOG2-1:0] run_cnt;
  logic                accept;
  logic                run_last;
  logic                cmp;
  logic                unused_rnd_low;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign run_last = &run_cnt;
  assign cmp      = sn_lt(32'(rnd_in[RND_W-1 -: PREC]), 32'(value));

  // Only the top PREC bits of the sample take part in the compare.
  assign unused_rnd_low = ^rnd_in[RND_W-PREC-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rng_load   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:    if (accept) state_next = LOAD;
      LOAD: begin
        rng_load   = 1'b1;
        state_next = RUN;
      end
      RUN:     if (run_last) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value    <= '0;
      rng_seed <= '0;
      run_cnt  <= '0;
      sn_bit   <= 1'b0;
      sn_valid <= 1'b0;
    end else begin
      if (accept) begin
        value    <= in_value;
        rng_seed <= in_seed;
        run_cnt  <= '0;
      end
      if (state == RUN) begin
        run_cnt <= run_cnt + LEN_LOG2'(1);
        sn_bit  <= cmp;
      end
      // Each stream bit is visible the cycle after its compare.
      sn_valid <= (state == RUN);
    end
  end

  sc_ones_counter #(
    .W(LEN_LOG2 + 1)
  ) u_ones (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .inc   ((state == RUN) && cmp),
    .count (ones_count)
  );

endmodule

// File: tb/tb_halton_sng_ctrl.sv
// Directed bench: two controllers (N=4096 and N=16384), each paired with a Halton generator model.
module tb_halton_sng_ctrl;

  localparam int RND_W = 27;
  localparam int PREC  = 12;
  localparam int LA    = 12;
  localparam int LB    = 14;
  localparam int NA    = 1 << LA;
  localparam int NB    = 1 << LB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid_a = 1'b0;
  logic [PREC-1:0]  in_value_a = '0;
  logic [RND_W-1:0] in_seed_a  = '0;
  logic             in_ready_a, rng_load_a, sn_valid_a, sn_bit_a, done_a, busy_a;
  logic [RND_W-1:0] rng_seed_a, rnd_in_a;
  logic [RND_W-1:0] gen_a = '0;
  logic [LA:0]      ones_count_a;

  logic             in_valid_b = 1'b0;
  logic [PREC-1:0]  in_value_b = '0;
  logic [RND_W-1:0] in_seed_b  = '0;
  logic             in_ready_b, rng_load_b, sn_valid_b, sn_bit_b, done_b, busy_b;
  logic [RND_W-1:0] rng_seed_b, rnd_in_b;
  logic [RND_W-1:0] gen_b = '0;
  logic [LB:0]      ones_count_b;

  int checks = 0;
  int failures = 0;

  logic bit_q[$];
  int   cnt_q[$];
  int   bit_idx = 0;
  logic [3:0] first4 = '0;
  int   rng_loads = 0;
  int   streams_done = 0;

  halton_sng_ctrl #(.RND_W(RND_W), .PREC(PREC), .LEN_LOG2(LA)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_value(in_value_a), .in_seed(in_seed_a), .rng_load(rng_load_a),
    .rng_seed(rng_seed_a), .rnd_in(rnd_in_a), .sn_valid(sn_valid_a),
    .sn_bit(sn_bit_a), .done(done_a), .ones_count(ones_count_a), .busy(busy_a)
  );

  halton_sng_ctrl #(.RND_W(RND_W), .PREC(PREC), .LEN_LOG2(LB)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_value(in_value_b), .in_seed(in_seed_b), .rng_load(rng_load_b),
    .rng_seed(rng_seed_b), .rnd_in(rnd_in_b), .sn_valid(sn_valid_b),
    .sn_bit(sn_bit_b), .done(done_b), .ones_count(ones_count_b), .busy(busy_b)
  );

  function automatic logic [RND_W-1:0] rev(input logic [RND_W-1:0] x);
    logic [RND_W-1:0] r;
    for (int i = 0; i < RND_W; i++) r[i] = x[RND_W-1-i];
    return r;
  endfunction

  // Halton generator: registered counter, loaded from rng_seed, output bit-reversed.
  always @(posedge clk) gen_a <= rng_load_a ? rng_seed_a : gen_a + 27'd1;
  always @(posedge clk) gen_b <= rng_load_b ? rng_seed_b : gen_b + 27'd1;
  assign rnd_in_a = rev(gen_a);
  assign rnd_in_b = rev(gen_b);
  always @(posedge clk) if (rng_load_a) rng_loads <= rng_loads + 1;

  function automatic logic model_bit(input logic [RND_W-1:0] seed, input int k,
                                     input logic [PREC-1:0] v);
    logic [RND_W-1:0] s;
    s = rev(seed + RND_W'(k));
    return s[RND_W-1 -: PREC] < v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every stream bit and every done pulse pops an expectation.
  always @(negedge clk) begin
    logic exp_b;
    int   exp_c;
    if (reset) begin
      bit_idx = 0;
    end else begin
      if (sn_valid_a) begin
        exp_b = (bit_q.size() > 0) ? bit_q.pop_front() : 1'bx;
        chk("sn_bit", {63'd0, sn_bit_a}, {63'd0, exp_b});
        if (bit_idx < 4) first4[bit_idx] = sn_bit_a;
        bit_idx++;
      end
      if (done_a) begin
        chk("stream_len_remaining", 64'(bit_q.size()), 64'd0);
        chk("sn_valid_at_done", {63'd0, sn_valid_a}, 64'd0);
        exp_c = (cnt_q.size() > 0) ? cnt_q.pop_front() : -1;
        chk("ones_count", 64'(ones_count_a), 64'(exp_c));
        streams_done++;
        $display("stream %0d: bits=%0d ones_count=%0d expected=%0d",
                 streams_done, bit_idx, ones_count_a, exp_c);
        bit_idx = 0;
      end
    end
  end

  task automatic stream_a(input logic [PREC-1:0] v, input logic [RND_W-1:0] s,
                          input bit hold, output int done_cyc);
    int cyc;
    int exp_cnt;
    logic b;
    exp_cnt = 0;
    @(negedge clk);
    chk("in_ready_idle", {63'd0, in_ready_a}, 64'd1);
    in_valid_a = 1'b1;
    in_value_a = v;
    in_seed_a  = s;
    for (int k = 0; k < NA; k++) begin
      b = model_bit(s, k, v);
      bit_q.push_back(b);
      exp_cnt += int'(b);
    end
    cnt_q.push_back(exp_cnt);
    @(posedge clk);
    #1;
    if (!hold) in_valid_a = 1'b0;
    // Offered values while busy must not reach the stream.
    in_value_a = ~v;
    in_seed_a  = s ^ 27'h5A5A5A5;
    cyc = 1;
    while (cyc < NA + 20) begin
      @(negedge clk);
      if (cyc == 1) chk("rng_load_cycle1", {63'd0, rng_load_a}, 64'd1);
      if (cyc == 2) chk("busy_run", {63'd0, busy_a}, 64'd1);
      if (done_a) break;
      @(posedge clk);
      cyc++;
    end
    done_cyc = cyc;
  endtask

  initial begin
    int dc;
    int d;
    int loads0;
    int cyc;
    bit saw_done;
    logic [PREC-1:0] rv;
    logic [RND_W-1:0] rs;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready_a}, 64'd1);
    chk("rst_rng_load", {63'd0, rng_load_a}, 64'd0);
    chk("rst_rng_seed", 64'(rng_seed_a), 64'd0);
    chk("rst_sn_valid", {63'd0, sn_valid_a}, 64'd0);
    chk("rst_sn_bit", {63'd0, sn_bit_a}, 64'd0);
    chk("rst_done", {63'd0, done_a}, 64'd0);
    chk("rst_ones_count", 64'(ones_count_a), 64'd0);
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    reset = 1'b0;

    stream_a(12'h800, '0, 1'b0, dc);
    chk("done_cycle", 64'(dc), 64'(NA + 3));
    chk("half_count", 64'(ones_count_a), 64'd2048);
    chk("first_bits_1010", 64'(first4), 64'b0101);
    chk("in_ready_at_done", {63'd0, in_ready_a}, 64'd0);
    chk("busy_at_done", {63'd0, busy_a}, 64'd1);

    stream_a(12'h000, '0, 1'b0, dc);
    chk("zero_count", 64'(ones_count_a), 64'd0);

    stream_a(12'hFFF, '0, 1'b0, dc);
    chk("max_count", 64'(ones_count_a), 64'd4095);

    // in_valid held high across two streams
    loads0 = rng_loads;
    stream_a(12'h123, '0, 1'b1, dc);
    chk("hold_first_count", 64'(ones_count_a), 64'h123);
    chk("hold_in_ready_done", {63'd0, in_ready_a}, 64'd0);
    stream_a(12'h5A5, 27'h0123456, 1'b0, dc);
    chk("hold_second_done_cycle", 64'(dc), 64'(NA + 3));
    chk("rng_load_once_per_stream", 64'(rng_loads - loads0), 64'd2);

    for (int t = 0; t < 3; t++) begin
      rv = PREC'($urandom_range(0, (1 << PREC) - 1));
      rs = RND_W'($urandom_range(1, (1 << RND_W) - 1));
      stream_a(rv, rs, 1'b0, dc);
      d = int'(ones_count_a) - int'(rv);
      chk("random_near_value", {63'd0, (d >= -1 && d <= 1)}, 64'd1);
    end

    // abort mid-stream with reset
    @(negedge clk);
    in_valid_a = 1'b1;
    in_value_a = 12'h400;
    in_seed_a  = 27'd7;
    for (int k = 0; k < NA; k++) bit_q.push_back(model_bit(27'd7, k, 12'h400));
    cnt_q.push_back(1024);
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    repeat (101) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    bit_q.delete();
    cnt_q.delete();
    @(negedge clk);
    chk("abort_in_ready", {63'd0, in_ready_a}, 64'd1);
    chk("abort_rng_load", {63'd0, rng_load_a}, 64'd0);
    chk("abort_rng_seed", 64'(rng_seed_a), 64'd0);
    chk("abort_sn_valid", {63'd0, sn_valid_a}, 64'd0);
    chk("abort_sn_bit", {63'd0, sn_bit_a}, 64'd0);
    chk("abort_done", {63'd0, done_a}, 64'd0);
    chk("abort_ones_count", 64'(ones_count_a), 64'd0);
    chk("abort_busy", {63'd0, busy_a}, 64'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_done |= done_a;
    end
    chk("abort_no_done", {63'd0, saw_done}, 64'd0);
    stream_a(12'h9C4, '0, 1'b0, dc);
    chk("after_abort_count", 64'(ones_count_a), 64'd2500);

    // longer stream on the LEN_LOG2=14 instance
    @(negedge clk);
    in_valid_b = 1'b1;
    in_value_b = 12'h300;
    in_seed_b  = '0;
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    cyc = 1;
    while (cyc < NB + 20) begin
      @(negedge clk);
      if (done_b) break;
      @(posedge clk);
      cyc++;
    end
    chk("long_done_cycle", 64'(cyc), 64'(NB + 3));
    chk("long_count", 64'(ones_count_b), 64'd3072);
    $display("long stream: ones_count=%0d done_cycle=%0d", ones_count_b, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
